// File: rtl/shifter_if.sv
// Operand/result bus for the execute-stage barrel shifter.
interface shifter_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam int unsigned OP_W   = 2;

  logic [DATA_W-1:0] in;
  logic [OP_W-1:0]   shiftop;
  logic [AMT_W-1:0]  shiftamt;
  logic              in_valid;
  logic [DATA_W-1:0] result;
  logic              out_valid;

  modport master (output in, shiftop, shiftamt, in_valid, input result, out_valid);
  modport slave  (input in, shiftop, shiftamt, in_valid, output result, out_valid);
endinterface

// File: rtl/shifter.sv
// 32-bit barrel shifter (LSR/ASR/LSL, optional rotate right) with a single output register.
// Define SHIFTER_ROTATE_EN to make shiftop 2'b11 rotate right; otherwise 2'b11 passes the operand through.
module shifter (
  input  logic       clock,
  input  logic       reset,
  shifter_if.slave   bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;
  localparam logic [DATA_W-1:0] ONES = '1;

  logic [DATA_W-1:0] result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] net_in, net_x, shifted;
  logic              fill, rot, rev, bypass;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W); i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  // Left shift reuses the right-shift network on a bit-reversed operand.
  always_comb begin
    fill   = 1'b0;
    rot    = 1'b0;
    rev    = 1'b0;
    bypass = 1'b0;
    case (bus.shiftop)
      2'b00: ;
      2'b01: fill = bus.in[DATA_W-1];
      2'b10: rev  = 1'b1;
      2'b11: begin
`ifdef SHIFTER_ROTATE_EN
        rot    = 1'b1;
`else
        bypass = 1'b1;
`endif
      end
      default: ;
    endcase
    net_in = rev ? bit_rev(bus.in) : bus.in;
  end

  // Five cascaded stages: 16, 8, 4, 2, 1, each enabled by its shiftamt bit.
  always_comb begin
    net_x = net_in;
    for (int s = int'(AMT_W) - 1; s >= 0; s--) begin
      if (bus.shiftamt[s]) begin
        net_x = (net_x >> (1 << s)) |
                (rot  ? (net_x << (DATA_W - (1 << s))) :
                 fill ? ~(ONES >> (1 << s)) : '0);
      end
    end
  end

  always_comb begin
    shifted     = bypass ? bus.in : (rev ? bit_rev(net_x) : net_x);
    result_d    = bus.in_valid ? shifted : result_q;
    out_valid_d = bus.in_valid;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench for shifter: expected results queued at issue, compared when out_valid fires.
module tb_shifter;
  logic clock;
  logic reset;
  shifter_if bus ();

  shifter u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  int unsigned  pulses = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  last_exp = '0;

  function automatic logic [31:0] model(input logic [31:0] x, input logic [1:0] op,
                                        input logic [4:0] amt);
    case (op)
      2'b00:   return x >> amt;
      2'b01:   return 32'($signed(x) >>> amt);
      2'b10:   return x << amt;
      default: begin
`ifdef SHIFTER_ROTATE_EN
        if (amt == 5'd0) return x;
        return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
`else
        return x;
`endif
      end
    endcase
  endfunction

  // Scoreboard consumer
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: result=%h with empty scoreboard at %0t", bus.result, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.result !== e) begin
          errors++;
          $display("FAIL scoreboard: result=%h expected=%h at %0t", bus.result, e, $time);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [1:0] op, input logic [4:0] amt,
                       input logic [31:0] e);
    @(posedge clock); #1;
    bus.in = x; bus.shiftop = op; bus.shiftamt = amt; bus.in_valid = 1'b1;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_hold(input logic [31:0] e, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checks++;
      if (bus.result !== e || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s: result=%h out_valid=%b, required result=%h out_valid=0", tag,
                 bus.result, bus.out_valid, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in = 32'hFFFF_FFFF; bus.shiftop = 2'b00; bus.shiftamt = 5'd0; bus.in_valid = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.result !== 32'h0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h out_valid=%b, required 0/0", bus.result, bus.out_valid);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    issue(32'h1234_5678, 2'b00, 5'd4, 32'h0123_4567);
    idle(1);
    wait_drain();
  endtask

  task automatic test_directed();
    issue(32'h8000_0000, 2'b00, 5'd4,  32'h0800_0000);
    issue(32'h8000_0000, 2'b01, 5'd4,  32'hF800_0000);
    issue(32'h8000_0000, 2'b10, 5'd4,  32'h0000_0000);
    issue(32'h8000_0001, 2'b00, 5'd31, 32'h0000_0001);
    issue(32'h8000_0001, 2'b01, 5'd31, 32'hFFFF_FFFF);
    issue(32'h8000_0001, 2'b10, 5'd31, 32'h8000_0000);
    issue(32'hDEAD_BEEF, 2'b00, 5'd0,  32'hDEAD_BEEF);
    issue(32'hDEAD_BEEF, 2'b01, 5'd0,  32'hDEAD_BEEF);
    issue(32'hDEAD_BEEF, 2'b10, 5'd0,  32'hDEAD_BEEF);
    issue(32'hDEAD_BEEF, 2'b11, 5'd0,  32'hDEAD_BEEF);
`ifdef SHIFTER_ROTATE_EN
    issue(32'h0000_00F1, 2'b11, 5'd4,  32'h1000_000F);
`else
    issue(32'h0000_00F1, 2'b11, 5'd4,  32'h0000_00F1);
`endif
    idle(1);
    wait_drain();
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 1200; i++) begin
      logic [31:0] x;
      logic [1:0]  op;
      logic [4:0]  amt;
      x   = (i % 2 == 0) ? 32'($urandom_range(0, 65535)) : $urandom;
      op  = 2'(i % 4);
      amt = 5'(i % 32);
      issue(x, op, amt, model(x, op, amt));
    end
    idle(1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int unsigned p0;
    logic [31:0] x;
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      x = 32'h1111_1111 * 32'(i + 1);
      issue(x, 2'(i % 3), 5'(i * 3), model(x, 2'(i % 3), 5'(i * 3)));
    end
    idle(1);
    wait_drain();
    checks++;
    if (pulses - p0 != 8) begin
      errors++;
      $display("FAIL stream_pulses: got %0d out_valid pulses, required 8", pulses - p0);
    end
    check_hold(last_exp, 3, "stream_hold");
    // Input changes while in_valid is low must not disturb the output.
    bus.in = 32'hA5A5_5A5A; bus.shiftop = 2'b10; bus.shiftamt = 5'd7;
    check_hold(last_exp, 2, "no_valid_change");
  endtask

  task automatic test_reset_mid_op();
    issue(32'hCAFE_0000, 2'b00, 5'd8, 32'h00CA_FE00);
    idle(2);
    wait_drain();
    @(posedge clock); #1;
    bus.in = 32'h7777_7777; bus.shiftop = 2'b00; bus.shiftamt = 5'd1; bus.in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.result !== 32'h0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: result=%h out_valid=%b, required 0/0", bus.result, bus.out_valid);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check_hold(32'h0, 3, "reset_discard");
    issue(32'hF000_000F, 2'b10, 5'd4, 32'h0000_00F0);
    idle(1);
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shifter.md
# shifter

32-bit barrel shifter for the datapath execute stage, selecting logical right, arithmetic right, logical left or rotate right by a 5-bit amount. Operands and opcode are captured combinationally into a single output register, so the result appears one clock after the inputs are presented. The block feeds the ALU result mux and holds no state other than its output stage.

## Interface
Parameters:
- none; data width fixed at 32, amount width fixed at 5.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears output stage immediately.
- in  input  32  operand to be shifted.
- shiftop  input  2  operation select (see Operation).
- shiftamt  input  5  shift distance, 0..31, unsigned.
- in_valid  input  1  qualifies in/shiftop/shiftamt for capture this cycle.
- result  output  32  shifted operand, registered.
- out_valid  output  1  high for one cycle per accepted operation.

## Operation
- shiftop 2'b00: logical shift right; vacated MSBs filled with 0.
- shiftop 2'b01: arithmetic shift right; vacated MSBs filled with in[31].
- shiftop 2'b10: logical shift left; vacated LSBs filled with 0.
- shiftop 2'b11: rotate right by shiftamt (only with ROTATE enabled; see Configuration).
- Implementation: five cascaded mux stages (shift by 16, 8, 4, 2, 1), each stage enabled by the matching shiftamt bit; left shift uses the same right-shift network on a bit-reversed operand, result reversed back.
- shiftamt = 0: result equals in for every shiftop.
- shiftamt = 31: 00 gives {31'b0,in[31]}; 01 gives 32 copies of in[31]; 10 gives {in[0],31'b0}.
- Result width is exactly 32; bits shifted past either end are discarded (no carry/overflow output).
- in_valid low: result register holds its previous value; out_valid deasserts.

## Timing
- Latency: 1 cycle. Inputs sampled with in_valid=1 at rising edge N; result and out_valid=1 valid after edge N.
- Throughput: one operation per cycle; back-to-back in_valid accepted with no bubbles.
- No backpressure: consumer must take result in the cycle out_valid is high.
- Reset: result = 32'h0000_0000, out_valid = 0, asynchronously on reset assertion, held while reset high.
- First capture allowed at the first rising edge after reset deasserts.
- Reset asserted mid-operation: pending capture discarded; no out_valid pulse for it.
- Input changes without in_valid have no effect on outputs.

## Configuration
- Macro SHIFTER_ROTATE_EN.
- Defined: shiftop 2'b11 performs rotate right, result = (in >> shiftamt) | (in << (32 - shiftamt)), with shiftamt = 0 giving in.
- Not defined: shiftop 2'b11 is reserved and produces result = in unchanged (pass-through); out_valid behaves identically.

## Test plan
- Reset: assert reset with in_valid=1 and in=32'hFFFF_FFFF -> result=0, out_valid=0 during reset; first valid capture after release yields correct result one cycle later.
- Sweep: in from 0 through 65535, shiftamt 0..31, shiftop 00/01/10 -> result matches in>>amt, sign-filled >>amt, in<<amt respectively; no mismatches.
- Sign fill: in=32'h8000_0000, shiftamt=4 -> 00 gives 32'h0800_0000, 01 gives 32'hF800_0000, 10 gives 32'h0000_0000.
- Extremes: in=32'h8000_0001, shiftamt=31 -> 00 gives 32'h0000_0001, 01 gives 32'hFFFF_FFFF, 10 gives 32'h8000_0000.
- Rotate (SHIFTER_ROTATE_EN defined): in=32'h0000_00F1, shiftop=11, shiftamt=4 -> 32'h1000_000F; without macro -> 32'h0000_00F1.
- Streaming: in_valid high for 8 consecutive cycles with distinct operands, then low -> 8 consecutive out_valid pulses in order, result held after last.
